// File: rtl/router_fsm_pkg.sv
// Shared definitions for the router packet-control FSM.
//   NUM_PORTS    : number of destination ports (fixed at 3)
//   INVALID_ADDR : header address that is silently dropped
//   state_e      : 3-bit encoded FSM state
//   port_sel()   : picks the flag of one port out of a per-port vector
package router_fsm_pkg;

    localparam int unsigned NUM_PORTS    = 3;
    localparam logic [1:0]  INVALID_ADDR = 2'b11;

    typedef enum logic [2:0] {
        StDecodeAddress   = 3'd0,
        StLoadFirstData   = 3'd1,
        StLoadData        = 3'd2,
        StFifoFull        = 3'd3,
        StLoadAfterFull   = 3'd4,
        StLoadParity      = 3'd5,
        StCheckParityErr  = 3'd6,
        StWaitTillEmpty   = 3'd7
    } state_e;

    // Address 3 does not map to a port, so it reads as 0.
    function automatic logic port_sel(input logic [NUM_PORTS-1:0] flags,
                                      input logic [1:0]           addr);
        logic sel;
        case (addr)
            2'd0:    sel = flags[0];
            2'd1:    sel = flags[1];
            2'd2:    sel = flags[2];
            default: sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Control bundle between the router source side, router_sync/router_reg and the FSM.
//   Inputs to FSM  : pkt_valid, data_in[1:0], fifo_full, fifo_empty_0..2,
//                    soft_reset_0..2, parity_done, low_pkt_valid
//   Outputs of FSM : detect_add, lfd_state, ld_state, laf_state, full_state,
//                    write_enb_reg, rst_int_reg, busy
//   master : environment side (drives FSM inputs)
//   slave  : FSM side
interface router_fsm_if;
    import router_fsm_pkg::*;

    logic                 pkt_valid;
    logic [1:0]           data_in;
    logic                 fifo_full;
    logic                 fifo_empty_0;
    logic                 fifo_empty_1;
    logic                 fifo_empty_2;
    logic                 soft_reset_0;
    logic                 soft_reset_1;
    logic                 soft_reset_2;
    logic                 parity_done;
    logic                 low_pkt_valid;

    logic                 detect_add;
    logic                 lfd_state;
    logic                 ld_state;
    logic                 laf_state;
    logic                 full_state;
    logic                 write_enb_reg;
    logic                 rst_int_reg;
    logic                 busy;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
        input  write_enb_reg, rst_int_reg, busy
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
        output write_enb_reg, rst_int_reg, busy
    );

endinterface

// File: rtl/router_fsm.sv
// Packet-control FSM of the 1x3 router. Decodes the header address, sequences
// header/payload/parity loading, stalls on a full FIFO, waits on a busy
// destination and aborts on that destination's soft reset.
// Ports:
//   clock  : system clock, rising edge
//   resetn : asynchronous active-low reset (forces DECODE_ADDRESS)
//   bus    : router_fsm_if.slave control bundle (see interface header)
// Outputs are a pure Moore decode of the current state.
module router_fsm
    import router_fsm_pkg::*;
(
    input  logic           clock,
    input  logic           resetn,
    router_fsm_if.slave    bus
);

    state_e                 state_q, state_d;
    logic [1:0]             addr_q, addr_d;

    logic [NUM_PORTS-1:0]   fifo_empty;
    logic [NUM_PORTS-1:0]   soft_reset;
    logic                   empty_in;    // empty flag of the port named by data_in
    logic                   empty_q;     // empty flag of the latched destination
    logic                   soft_rst_q;  // soft reset of the latched destination

    assign fifo_empty = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign soft_reset = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};

    assign empty_in   = port_sel(fifo_empty, bus.data_in);
    assign empty_q    = port_sel(fifo_empty, addr_q);
    assign soft_rst_q = port_sel(soft_reset, addr_q);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StDecodeAddress;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;

        if (state_q == StDecodeAddress && bus.pkt_valid) begin
            addr_d = bus.data_in;
        end

        case (state_q)
            StDecodeAddress: begin
                if (bus.pkt_valid && bus.data_in != INVALID_ADDR) begin
                    state_d = empty_in ? StLoadFirstData : StWaitTillEmpty;
                end
            end
            StLoadFirstData: state_d = StLoadData;
            StLoadData: begin
                // A full FIFO wins over end-of-packet.
                if (bus.fifo_full) begin
                    state_d = StFifoFull;
                end else if (!bus.pkt_valid) begin
                    state_d = StLoadParity;
                end
            end
            StFifoFull: begin
                if (!bus.fifo_full) begin
                    state_d = StLoadAfterFull;
                end
            end
            StLoadAfterFull: begin
                if (bus.parity_done) begin
                    state_d = StDecodeAddress;
                end else if (bus.low_pkt_valid) begin
                    state_d = StLoadParity;
                end else begin
                    state_d = StLoadData;
                end
            end
            StLoadParity:     state_d = StCheckParityErr;
            StCheckParityErr: state_d = bus.fifo_full ? StFifoFull : StDecodeAddress;
            StWaitTillEmpty: begin
                if (empty_q) begin
                    state_d = StLoadFirstData;
                end
            end
            default:          state_d = StDecodeAddress;
        endcase

        // Destination timeout aborts the packet from any active state.
        if (state_q != StDecodeAddress && soft_rst_q) begin
            state_d = StDecodeAddress;
        end
    end

    // Moore output decode
    always_comb begin
        bus.detect_add    = 1'b0;
        bus.lfd_state     = 1'b0;
        bus.ld_state      = 1'b0;
        bus.laf_state     = 1'b0;
        bus.full_state    = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.rst_int_reg   = 1'b0;
        bus.busy          = 1'b1;

        case (state_q)
            StDecodeAddress: begin
                bus.detect_add = 1'b1;
                bus.busy       = 1'b0;
            end
            StLoadFirstData: bus.lfd_state = 1'b1;
            StLoadData: begin
                bus.ld_state      = 1'b1;
                bus.write_enb_reg = 1'b1;
                bus.busy          = 1'b0;
            end
            StFifoFull:      bus.full_state = 1'b1;
            StLoadAfterFull: begin
                bus.laf_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            StLoadParity:     bus.write_enb_reg = 1'b1;
            StCheckParityErr: bus.rst_int_reg   = 1'b1;
            StWaitTillEmpty:  bus.busy          = 1'b1;
            default: begin
                bus.detect_add = 1'b1;
                bus.busy       = 1'b0;
            end
        endcase
    end

endmodule
